ga_req_arbiter: RTL

- Shares one GA coprocessor request/response port between NumReq requesters, e.g. the Ibex core, a debug/DMA master and a test sequencer.
- Round-robin arbitration with exactly one operation outstanding.
- Registers the accepted request, drives it to the coprocessor, waits for its response and returns that response only to the granted requester.
- Sits between the requesters and ga_coprocessor.ga_req_i / ga_resp_o.

---
 rtl/ga_pkg.sv | 28 ++
 rtl/ga_rr_picker.sv | 30 +++
 rtl/ga_req_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ga_pkg.sv
// Shared GA coprocessor types: request/response payloads and the request-arbiter state/limits.
package ga_pkg;

   typedef struct packed {
      logic        valid;
      logic [3:0]  op;
      logic [31:0] operand_a;
      logic [31:0] operand_b;
   } ga_req_t;

   typedef struct packed {
      logic        ready;
      logic        valid;
      logic        error;
      logic [31:0] result;
   } ga_resp_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } ga_arb_state_e;

   localparam int unsigned GA_ARB_MAX_REQ   = 8;
   localparam int unsigned GA_ARB_TIMEOUT_W = 16;

endpackage

// File: rtl/ga_rr_picker.sv
// Combinational round-robin select: first valid requester after last_i, wrapping modulo NumReq.
module ga_rr_picker #(
   parameter  int unsigned NumReq = 2,
   localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic [NumReq-1:0] valid_i,
   input  logic [IdxW-1:0]   last_i,
   output logic [IdxW-1:0]   winner_o,
   output logic              any_valid_o
);

   int unsigned     cand;
   logic [IdxW-1:0] cand_idx;

   always_comb begin
      winner_o    = '0;
      any_valid_o = 1'b0;
      cand        = 0;
      cand_idx    = '0;
      for (int unsigned off = 1; off <= NumReq; off++) begin
         cand     = (32'(last_i) + off) % NumReq;
         cand_idx = IdxW'(cand);
         if (!any_valid_o && valid_i[cand_idx]) begin
            any_valid_o = 1'b1;
            winner_o    = cand_idx;
         end
      end
   end

endmodule

// File: rtl/ga_req_arbiter.sv
// Round-robin arbiter sharing one GA coprocessor port among NumReq requesters, one op in flight.
// Optional WAIT watchdog with sticky timeout_o is enabled by defining GA_ARB_WATCHDOG_EN.
module ga_req_arbiter
   import ga_pkg::*;
#(
   parameter  int unsigned NumReq        = 2,
`ifdef GA_ARB_WATCHDOG_EN
   parameter  int unsigned TimeoutCycles = 1024,
`endif
   localparam int unsigned IdxW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NumReq-1:0] req_valid_i,
   input  ga_req_t           req_i [NumReq],
   output logic [NumReq-1:0] req_ready_o,
   output logic [NumReq-1:0] resp_valid_o,
   output ga_resp_t          resp_o,
   output ga_req_t           cop_req_o,
   input  ga_resp_t          cop_resp_i,
   output logic              busy_o,
   output logic [IdxW-1:0]   grant_idx_o,
   output logic [31:0]       grant_cnt_o
`ifdef GA_ARB_WATCHDOG_EN
   ,
   output logic              timeout_o
`endif
);

   if (NumReq < 2 || NumReq > GA_ARB_MAX_REQ) begin : g_bad_numreq
      $error("ga_req_arbiter: NumReq out of range");
   end

   ga_arb_state_e     state_q, state_d;
   logic [IdxW-1:0]   last_q, gidx_q, winner;
   logic              any_valid, accept, take_resp;
   ga_req_t           req_q;
   ga_resp_t          resp_q;
   logic [NumReq-1:0] resp_valid_q, grant_oh;
   logic [31:0]       cnt_q;

   ga_rr_picker #(.NumReq(NumReq)) u_picker (
      .valid_i     (req_valid_i),
      .last_i      (last_q),
      .winner_o    (winner),
      .any_valid_o (any_valid)
   );

   assign grant_oh = NumReq'(1) << gidx_q;

`ifdef GA_ARB_WATCHDOG_EN
   logic [GA_ARB_TIMEOUT_W-1:0] wd_q;
   logic                        timeout_q, take_timeout, wd_expired;
   ga_resp_t                    timeout_resp;

   assign wd_expired = (wd_q == GA_ARB_TIMEOUT_W'(TimeoutCycles));

   always_comb begin
      timeout_resp       = '0;
      timeout_resp.error = 1'b1;
      timeout_resp.valid = 1'b1;
   end

   // Counter sits at zero through ISSUE so it starts from zero on the first WAIT cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q == ISSUE) begin
            wd_q <= '0;
         end else if (state_q == WAIT) begin
            wd_q <= wd_q + GA_ARB_TIMEOUT_W'(1);
         end
         if (take_timeout) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout_o = timeout_q;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_ready_o = '0;
      accept      = 1'b0;
      take_resp   = 1'b0;
`ifdef GA_ARB_WATCHDOG_EN
      take_timeout = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (any_valid) begin
               req_ready_o[winner] = 1'b1;
               accept              = 1'b1;
               state_d             = ISSUE;
            end
         end
         ISSUE: begin
            if (cop_resp_i.ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A real response in the expiry cycle takes precedence over the timeout.
            if (cop_resp_i.valid) begin
               take_resp = 1'b1;
               state_d   = RESP;
            end
`ifdef GA_ARB_WATCHDOG_EN
            else if (wd_expired) begin
               take_timeout = 1'b1;
               state_d      = RESP;
            end
`endif
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q       <= IdxW'(NumReq - 1);
         gidx_q       <= '0;
         req_q        <= '0;
         resp_q       <= '0;
         resp_valid_q <= '0;
         cnt_q        <= '0;
      end else begin
         resp_valid_q <= '0;
         if (accept) begin
            req_q  <= req_i[winner];
            gidx_q <= winner;
            last_q <= winner;
            if (cnt_q != '1) begin
               cnt_q <= cnt_q + 32'd1;
            end
         end
         if (take_resp) begin
            resp_q       <= cop_resp_i;
            resp_valid_q <= grant_oh;
         end
`ifdef GA_ARB_WATCHDOG_EN
         if (take_timeout) begin
            resp_q       <= timeout_resp;
            resp_valid_q <= grant_oh;
         end
`endif
      end
   end

   always_comb begin
      cop_req_o       = req_q;
      cop_req_o.valid = (state_q == ISSUE);
   end

   assign resp_valid_o = resp_valid_q;
   assign resp_o       = resp_q;
   assign busy_o       = (state_q != IDLE);
   assign grant_idx_o  = gidx_q;
   assign grant_cnt_o  = cnt_q;

endmodule
